// File: rtl/linea_retardo_nbits.sv
// linea_retardo_nbits: DEPTH-stage sample delay line with fill status, overrun flag and tap scanner.
// The scanner streams the stored taps newest-first to the downstream MAC.
module linea_retardo_nbits #(
    parameter int BITS  = 20,
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [BITS-1:0]  entrada,
    input  logic             clear,
    input  logic             start,
    output logic [BITS-1:0]  salida,
    output logic [BITS-1:0]  tap_data,
    output logic [IDX_W-1:0] tap_idx,
    output logic             tap_valid,
    output logic             tap_last,
    output logic             busy,
    output logic             full,
    output logic             overrun
);
    localparam int IW = IDX_W + 1;
    localparam logic [IDX_W:0] LAST    = IW'(DEPTH - 1);
    localparam logic [IDX_W:0] CNT_MAX = IW'(DEPTH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          r_state, w_next;
    logic [BITS-1:0] r_d [DEPTH];
    logic [IDX_W:0]  r_cnt, r_idx, w_idx_next;
    logic            r_ovr;
    logic            w_push;

    // Pushes are only accepted while idle so taps stay frozen for a whole scan.
    assign w_push = en && !clear && r_state == IDLE;

    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        if (clear) begin
            w_next     = IDLE;
            w_idx_next = '0;
        end else if (r_state == IDLE) begin
            w_next     = start ? SCAN : IDLE;
            w_idx_next = '0;
        end else begin
            w_next     = r_idx == LAST ? IDLE : SCAN;
            w_idx_next = r_idx == LAST ? '0 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            if (clear)
                r_cnt <= '0;
            else if (w_push && r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
            if (clear)
                r_ovr <= 1'b0;
            else if (en && r_state == SCAN)
                r_ovr <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) r_d[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < DEPTH; k++) r_d[k] <= '0;
        end else if (w_push) begin
            r_d[0] <= entrada;
            for (int k = 1; k < DEPTH; k++) r_d[k] <= r_d[k-1];
        end
    end

    assign salida    = r_d[DEPTH-1];
    assign busy      = r_state == SCAN;
    assign tap_valid = busy;
    assign tap_idx   = r_idx[IDX_W-1:0];
    assign tap_data  = tap_valid ? r_d[r_idx[IDX_W-1:0]] : '0;
    assign tap_last  = tap_valid && r_idx == LAST;
    assign full      = r_cnt == CNT_MAX;
    assign overrun   = r_ovr;
endmodule

// File: tb/tb_linea_retardo_nbits.sv
// tb_linea_retardo_nbits: table-driven checks of the delay line and tap scanner (BITS=8, DEPTH=4).
module tb_linea_retardo_nbits;
    logic       clk = 0;
    logic       reset = 1;
    logic       en = 0, clear = 0, start = 0;
    logic [7:0] entrada = '0;
    logic [7:0] salida, tap_data;
    logic [1:0] tap_idx;
    logic       tap_valid, tap_last, busy, full, overrun;
    int         n_total = 0, n_pass = 0;

    typedef struct {
        logic       e;
        logic [7:0] din;
        logic       c, s;
        logic [7:0] sal;
        logic       f, b, o;
        logic [1:0] ix;
        logic [7:0] td;
        logic       l;
    } vec_t;

    vec_t vecs[$];

    linea_retardo_nbits #(.BITS(8), .DEPTH(4), .IDX_W(2)) dut (
        .clk(clk), .reset(reset), .en(en), .entrada(entrada), .clear(clear), .start(start),
        .salida(salida), .tap_data(tap_data), .tap_idx(tap_idx), .tap_valid(tap_valid),
        .tap_last(tap_last), .busy(busy), .full(full), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic e, input logic [7:0] din, input logic c, input logic s,
                               input logic [7:0] sal, input logic f, input logic b, input logic o,
                               input logic [1:0] ix, input logic [7:0] td, input logic l);
        vec_t r;
        r.e = e; r.din = din; r.c = c; r.s = s; r.sal = sal; r.f = f;
        r.b = b; r.o = o; r.ix = ix; r.td = td; r.l = l;
        return r;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s[%0d] got %0h expected %0h", nm, i, act, exp);
        else n_pass++;
    endtask

    task automatic check_all(input int i, input vec_t x);
        chk("salida", i, 32'(salida), 32'(x.sal));
        chk("full", i, 32'(full), 32'(x.f));
        chk("busy", i, 32'(busy), 32'(x.b));
        chk("tap_valid", i, 32'(tap_valid), 32'(x.b));
        chk("overrun", i, 32'(overrun), 32'(x.o));
        chk("tap_idx", i, 32'(tap_idx), 32'(x.ix));
        chk("tap_data", i, 32'(tap_data), 32'(x.td));
        chk("tap_last", i, 32'(tap_last), 32'(x.l));
    endtask

    task automatic step(input logic e, input logic [7:0] din, input logic c, input logic s);
        en = e; entrada = din; clear = c; start = s;
        @(posedge clk); #1;
        en = 0; clear = 0; start = 0;
    endtask

    initial begin
        // Test 1: fill and delay
        vecs.push_back(v(1, 8'h11, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(v(1, 8'h22, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(v(1, 8'h33, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(v(1, 8'h44, 0, 0, 8'h11, 1, 0, 0, 0, 8'h00, 0));
        vecs.push_back(v(1, 8'h55, 0, 0, 8'h22, 1, 0, 0, 0, 8'h00, 0));
        // Test 2: scan of 55,44,33,22
        vecs.push_back(v(0, 8'h00, 0, 1, 8'h22, 1, 1, 0, 0, 8'h55, 0));
        vecs.push_back(v(0, 8'h00, 0, 0, 8'h22, 1, 1, 0, 1, 8'h44, 0));
        vecs.push_back(v(0, 8'h00, 0, 0, 8'h22, 1, 1, 0, 2, 8'h33, 0));
        vecs.push_back(v(0, 8'h00, 0, 0, 8'h22, 1, 1, 0, 3, 8'h22, 1));
        vecs.push_back(v(0, 8'h00, 0, 0, 8'h22, 1, 0, 0, 0, 8'h00, 0));
        // Tests 3/4: push with start, rejected push mid-scan, clear
        vecs.push_back(v(1, 8'h99, 0, 1, 8'h33, 1, 1, 0, 0, 8'h99, 0));
        vecs.push_back(v(0, 8'h00, 0, 0, 8'h33, 1, 1, 0, 1, 8'h55, 0));
        vecs.push_back(v(1, 8'h77, 0, 0, 8'h33, 1, 1, 1, 2, 8'h44, 0));
        vecs.push_back(v(0, 8'h00, 0, 0, 8'h33, 1, 1, 1, 3, 8'h33, 1));
        vecs.push_back(v(0, 8'h00, 0, 0, 8'h33, 1, 0, 1, 0, 8'h00, 0));
        vecs.push_back(v(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        // Test 5: clear aborts a scan; en/start alongside clear are dropped
        vecs.push_back(v(1, 8'h11, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(v(1, 8'h22, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(v(1, 8'h33, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(v(1, 8'h44, 0, 0, 8'h11, 1, 0, 0, 0, 8'h00, 0));
        vecs.push_back(v(0, 8'h00, 0, 1, 8'h11, 1, 1, 0, 0, 8'h44, 0));
        vecs.push_back(v(0, 8'h00, 0, 0, 8'h11, 1, 1, 0, 1, 8'h33, 0));
        vecs.push_back(v(1, 8'h66, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        // Held start: zero taps, start ignored in SCAN, one IDLE cycle, then rescan
        vecs.push_back(v(0, 8'h00, 0, 1, 8'h00, 0, 1, 0, 0, 8'h00, 0));
        vecs.push_back(v(0, 8'h00, 0, 1, 8'h00, 0, 1, 0, 1, 8'h00, 0));
        vecs.push_back(v(0, 8'h00, 0, 1, 8'h00, 0, 1, 0, 2, 8'h00, 0));
        vecs.push_back(v(0, 8'h00, 0, 1, 8'h00, 0, 1, 0, 3, 8'h00, 1));
        vecs.push_back(v(0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(v(0, 8'h00, 0, 1, 8'h00, 0, 1, 0, 0, 8'h00, 0));
        vecs.push_back(v(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 1, 8'h00, 0));
        vecs.push_back(v(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 2, 8'h00, 0));
        vecs.push_back(v(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 3, 8'h00, 1));
        vecs.push_back(v(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));

        repeat (2) @(posedge clk);
        #1;
        check_all(-1, v(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        reset = 0;

        foreach (vecs[i]) begin
            step(vecs[i].e, vecs[i].din, vecs[i].c, vecs[i].s);
            check_all(i, vecs[i]);
        end

        // Test 6: asynchronous reset between edges mid-scan
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        step(0, 8'h00, 0, 1);
        check_all(100, v(0, 8'h00, 0, 0, 8'h11, 1, 1, 0, 0, 8'h44, 0));
        #2 reset = 1;
        #1 check_all(101, v(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        #1 reset = 0;
        step(1, 8'hAB, 0, 0);
        check_all(102, v(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/linea_retardo_nbits.md
Name: linea_retardo_nbits

Overview:
- Parametrised successor of the single n-bit enabled register: a DEPTH-stage, BITS-wide sample delay line for the equalizer FIR path.
- Each accepted sample shifts through the stages.
- A built-in tap scanner streams all stored taps, newest first, one per clock to the downstream MAC.
- Also provides fill status, an overrun flag and a synchronous flush.

Parameters:
- BITS, 20, sample width in bits.
- DEPTH, 16, number of delay stages/taps; legal range 2 to 256.
- IDX_W, 4, tap index width; must equal ceil(log2(DEPTH)).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- en  input  1  push request; entrada is sampled at this edge.
- entrada  input  BITS  sample to push.
- clear  input  1  synchronous flush of stages, fill count, overrun and scan.
- start  input  1  begin tap scan.
- salida  output  BITS  oldest stage, d[DEPTH-1].
- tap_data  output  BITS  tap value during a scan.
- tap_idx  output  IDX_W  index of the tap on tap_data.
- tap_valid  output  1  tap_data/tap_idx are valid this cycle.
- tap_last  output  1  current tap is index DEPTH-1.
- busy  output  1  scanner in SCAN state.
- full  output  1  DEPTH samples accepted since reset/clear.
- overrun  output  1  sticky: a push was rejected.

Behaviour:
- Storage: registers d[0..DEPTH-1]; d[0] holds the newest sample.
- Reset (async, active-high): all d = 0, fill count = 0, state = IDLE, idx = 0, overrun = 0. Resulting outputs: salida=0, tap_data=0, tap_idx=0, tap_valid=0, tap_last=0, busy=0, full=0, overrun=0.
- Priority per edge: reset > clear > (push, start).
- Push (en=1, clear=0, state IDLE):
  - d[0] <= entrada; d[k] <= d[k-1] for k=1..DEPTH-1.
  - Fill count increments, saturating at DEPTH.
  - full = (count == DEPTH).
  - salida reflects the new d[DEPTH-1] after the edge, i.e. delay = DEPTH accepted pushes.
- en=0: all stages hold.
- Push while busy=1: sample dropped, stages unchanged, overrun <= 1. overrun stays set until clear or reset.
- FSM states: IDLE, SCAN.
  - IDLE -> SCAN on start=1 with clear=0; idx <= 0.
  - SCAN: idx increments each cycle. When idx == DEPTH-1, next state is IDLE and idx <= 0.
  - start while in SCAN is ignored.
  - A scan lasts exactly DEPTH cycles, and a new start is accepted in the cycle busy falls.
  - Back-to-back scans: start held high yields SCAN, then one IDLE cycle, then SCAN.
- Outputs during scan:
  - busy = tap_valid = (state == SCAN).
  - tap_idx = idx.
  - tap_data = d[idx] (combinational mux of registered state) when tap_valid=1, else 0.
  - tap_last = tap_valid && idx == DEPTH-1.
- Latency: start sampled at edge N gives the first tap (idx 0) in cycle N+1 and the last tap in cycle N+DEPTH.
- Push and start in the same IDLE cycle: push accepted, scan starts; tap 0 equals that entrada.
- Taps are stable through a scan because pushes are rejected while busy.
- Scanning before full is allowed; unfilled taps read 0.
- clear=1:
  - d = 0, count = 0, full = 0, overrun = 0, state = IDLE, idx = 0; tap_valid=0 from the next cycle.
  - Aborts a scan mid-stream without asserting tap_last.
  - en with clear: sample dropped, no overrun. start with clear: ignored.
- Reset mid-scan: immediate return to IDLE with all outputs 0.
- Widths: no arithmetic on data. idx and count use IDX_W+1 bits internally, so count==DEPTH is representable when DEPTH is a power of two.

Test Plan:
1. BITS=8, DEPTH=4 (IDX_W=2): reset, push 0x11,0x22,0x33 -> full=0, salida=0. Push 0x44 -> full=1, salida=0x11. Push 0x55 -> salida=0x22, full stays 1.
2. After push 0x11..0x44, pulse start -> next 4 cycles tap_idx=0..3, tap_data=0x44,0x33,0x22,0x11, tap_valid=1 and busy=1 throughout, tap_last only on idx 3. busy=0 in cycle 5.
3. Same cycle en=1 (0x99) and start=1 in IDLE -> tap 0 = 0x99, tap 1 = previous newest sample.
4. Push 0x77 on cycle 2 of a scan -> stages unchanged, remaining taps unchanged, overrun=1 and stays 1 after scan. Later pulse clear -> overrun=0, full=0, salida=0.
5. clear asserted on scan cycle 2 (of 4) -> next cycle tap_valid=0, busy=0, tap_last never asserted. Subsequent start gives 4 taps of 0x00.
6. Async reset pulse between clock edges mid-scan with full=1 -> all outputs 0 immediately, before the next edge. After release, push 0xAB -> salida=0, full=0.
